program_loader: RTL
===================

Name: program_loader

Overview:
- Writer side of the 4-bit computer's program-load interface.
- Receives a byte-stream program frame over a valid/ready handshake and writes each word into the computer's instruction and data memories by driving ins_address, ins and d_in.
- Holds the computer in load mode (its rst high) until a frame's checksum verifies, then releases it to run.
- Replaces bench-driven loading in system tops.

Parameters:
- START_BYTE, 8'hA5, frame delimiter
- TIMEOUT_CYC, 255, inter-byte timeout in clk cycles (used only with LOADER_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s_data  in  8  incoming frame byte
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts byte; transfer when s_valid & s_ready at rising clk
- reload  in  1  single-cycle request to re-enter load mode
- core_load  out  1  drives computer rst; 1 = load/hold, 0 = run
- ld_address  out  4  memory address to computer (ins_address)
- ld_ins  out  8  instruction byte to computer (ins)
- ld_din  out  4  data nibble to computer (d_in)
- ld_we  out  1  one-cycle write strobe, aligned with ld_* values
- done  out  1  frame loaded and verified; computer running
- err  out  1  last frame rejected (sticky until next accepted START_BYTE)

Behaviour:
- Reset (rst=0, async): state HUNT; core_load=1; ld_address/ld_ins/ld_din=0; ld_we=0; done=0; err=0; s_ready=0 while rst low. Reset mid-frame aborts the frame; no partial release.
- Frame format: START_BYTE, COUNT, then N pairs {INS, DATA}, then CSUM.
  - COUNT[3:0] = N-1 (N = 1..16); COUNT[7:4] must be 0.
  - DATA[3:0] is the nibble; DATA[7:4] is ignored but included in the checksum.
  - CSUM = XOR of COUNT and all INS and DATA bytes (START excluded).
- States:
  - HUNT: s_ready=1; non-START bytes discarded. START → COUNT; clears err, zeroes checksum and word index.
  - COUNT: s_ready=1. Upper nibble ≠0 → err=1, HUNT. Else latch N-1 → INS.
  - INS: s_ready=1; latch ld_ins → DATA.
  - DATA: s_ready=1; latch ld_din, ld_address=index → WRITE.
  - WRITE: s_ready=0; ld_we=1 for exactly one cycle. If index == N-1 → CSUM; else index+1 → INS.
  - CSUM: s_ready=1. Match → RUN; mismatch → err=1, HUNT, core_load stays 1.
  - RUN: core_load=0, done=1, s_ready=0. reload=1 → HUNT, core_load=1, done=0 next cycle.
- Words are written to addresses 0..N-1 in order. Addresses ≥N are untouched.
- ld_* hold their last values between strobes. Each pair consumes a minimum of 3 cycles.
- reload outside RUN is ignored. A second START inside a frame is treated as data.
- core_load never drops before CSUM matches; from CSUM acceptance to core_load=0 is 1 cycle.
- Checksum is an 8-bit XOR accumulator with no carry and wraps freely.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN
- Defined: an 8-bit counter resets on every accepted byte and counts while in COUNT/INS/DATA/CSUM with no transfer. Reaching TIMEOUT_CYC → err=1, HUNT, core_load=1. The counter is idle in HUNT, WRITE and RUN.
- Undefined: no counter; the loader waits indefinitely mid-frame.

Decomposition:
- Shared include loader_defs.vh: state encodings (HUNT, COUNT, INS, DATA, WRITE, CSUM, RUN), default START_BYTE, COUNT field positions.
- One natural sub-module: loader_csum (XOR accumulator with clear, enable, byte in, 8-bit sum out).
- FSM, index counter and ld_* registers stay in program_loader.

Test Plan:
- Valid frame A5,01,16,00,02,03,16:
  - ld_we pulses twice: (addr0, ins 16, din 0), then (addr1, ins 02, din 3).
  - core_load falls one cycle after CSUM; done=1; err=0.
- Same frame with CSUM 17 → err=1, core_load stays 1, done=0, state HUNT. Resend the correct frame → err clears on A5, then load succeeds.
- Bytes 00,FF,3C, then a valid frame → junk discarded, no ld_we, correct load.
- COUNT=0x1F → err=1 immediately, return to HUNT, no ld_we.
- In RUN, pulse reload → core_load=1, done=0. Then a 16-word frame (COUNT=0F) → addresses 0..F written once each, in order.
- rst low during the INS of word 3 → all outputs at reset values, core_load=1.
- With LOADER_TIMEOUT_EN: stall s_valid for 255 cycles after COUNT → err=1, HUNT.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding,
// frame delimiter default, COUNT byte field positions and memory widths.
// Imported by program_loader and loader_csum.
package program_loader_pkg;

    // Loader FSM states, in frame order
    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_COUNT = 3'd1,
        ST_INS   = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_CSUM  = 3'd5,
        ST_RUN   = 3'd6
    } state_t;

    // Default frame delimiter
    localparam logic [7:0] DEFAULT_START_BYTE = 8'hA5;

    // COUNT byte layout: [3:0] = N-1, [7:4] reserved (must be zero)
    localparam int COUNT_N_LSB    = 0;
    localparam int COUNT_N_MSB    = 3;
    localparam int COUNT_RSVD_LSB = 4;
    localparam int COUNT_RSVD_MSB = 7;

    // Computer memory port widths
    localparam int ADDR_W = 4;
    localparam int INS_W  = 8;
    localparam int DIN_W  = 4;

    // States in which the loader is waiting on a frame byte
    function automatic logic takes_bytes(input state_t s);
        return (s == ST_HUNT) || (s == ST_COUNT) || (s == ST_INS) ||
               (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/loader_csum.sv
// Purpose: 8-bit XOR accumulator over frame bytes, with synchronous clear.
// Latency: sum reflects a byte one cycle after en; clear takes effect next cycle.
// Backpressure: none; the caller decides when a byte counts via en.
module loader_csum
    import program_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    // Accumulate XOR of accepted bytes; clear has priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (en) begin
            sum <= sum ^ din;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Purpose: receive a program frame over valid/ready and write it into the 4-bit computer's memories, then release it.
// Latency: each {INS,DATA} pair takes >=3 cycles (INS, DATA, WRITE); core_load drops 1 cycle after CSUM is accepted.
// Backpressure: s_ready low in WRITE, RUN and during reset; optional inter-byte timeout under LOADER_TIMEOUT_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [7:0] START_BYTE = DEFAULT_START_BYTE
`ifdef LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              reload,
    output logic              core_load,
    output logic [ADDR_W-1:0] ld_address,
    output logic [INS_W-1:0]  ld_ins,
    output logic [DIN_W-1:0]  ld_din,
    output logic              ld_we,
    output logic              done,
    output logic              err
);

    state_t            state;
    state_t            state_nxt;
    logic              armed;
    logic              accept;
    logic              in_frame;
    logic              timeout;
    logic [ADDR_W-1:0] cnt_n;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        csum_sum;

    // FSM control strobes
    logic csum_clr;
    logic csum_en;
    logic err_set;
    logic err_clr;
    logic cnt_latch;
    logic ins_latch;
    logic din_latch;
    logic idx_clr;
    logic idx_inc;

    // armed is low throughout reset so s_ready cannot assert until reset is released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    assign s_ready   = armed & takes_bytes(state);
    assign accept    = s_valid & s_ready;
    assign in_frame  = (state == ST_COUNT) || (state == ST_INS) ||
                       (state == ST_DATA)  || (state == ST_CSUM);
    assign ld_we     = (state == ST_WRITE);
    assign core_load = (state != ST_RUN);
    assign done      = (state == ST_RUN);

`ifdef LOADER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] to_cnt;

    assign timeout = in_frame & ~accept & (to_cnt == TO_LAST);

    // Count stalled cycles mid-frame; any accepted byte or leaving the frame restarts it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= 8'h00;
        end else if (!in_frame || accept || timeout) begin
            to_cnt <= 8'h00;
        end else begin
            to_cnt <= to_cnt + 8'h01;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nxt = state;
        csum_clr  = 1'b0;
        csum_en   = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        cnt_latch = 1'b0;
        ins_latch = 1'b0;
        din_latch = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        case (state)
            ST_HUNT: begin
                if (accept && (s_data == START_BYTE)) begin
                    state_nxt = ST_COUNT;
                    csum_clr  = 1'b1;
                    err_clr   = 1'b1;
                    idx_clr   = 1'b1;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    if (s_data[COUNT_RSVD_MSB:COUNT_RSVD_LSB] != 4'h0) begin
                        err_set   = 1'b1;
                        state_nxt = ST_HUNT;
                    end else begin
                        cnt_latch = 1'b1;
                        csum_en   = 1'b1;
                        state_nxt = ST_INS;
                    end
                end
            end
            ST_INS: begin
                if (accept) begin
                    ins_latch = 1'b1;
                    csum_en   = 1'b1;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    din_latch = 1'b1;
                    csum_en   = 1'b1;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (idx == cnt_n) begin
                    state_nxt = ST_CSUM;
                end else begin
                    idx_inc   = 1'b1;
                    state_nxt = ST_INS;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (s_data == csum_sum) begin
                        state_nxt = ST_RUN;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = ST_HUNT;
                    end
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_nxt = ST_HUNT;
                end
            end
            default: begin
                state_nxt = ST_HUNT;
            end
        endcase
        // A stall timeout only fires on a cycle with no transfer, so no latch strobe is active here
        if (timeout) begin
            state_nxt = ST_HUNT;
            err_set   = 1'b1;
        end
    end

    // Word count, index, memory-port registers and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_n      <= '0;
            idx        <= '0;
            ld_address <= '0;
            ld_ins     <= '0;
            ld_din     <= '0;
            err        <= 1'b0;
        end else begin
            if (cnt_latch) begin
                cnt_n <= s_data[COUNT_N_MSB:COUNT_N_LSB];
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 4'd1;
            end
            if (ins_latch) begin
                ld_ins <= s_data;
            end
            if (din_latch) begin
                ld_din     <= s_data[DIN_W-1:0];
                ld_address <= idx;
            end
            if (err_clr) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    loader_csum u_csum (
        .clk (clk),
        .rst (rst),
        .clr (csum_clr),
        .en  (csum_en),
        .din (s_data),
        .sum (csum_sum)
    );

endmodule
